// File: rtl/demux_decoded_registered.sv
// Registered one-hot demultiplexer. One input word is steered into one of
// NUM_WAY single-entry output slots, each with its own valid/ready handshake,
// so a stalled consumer only blocks traffic aimed at its own way.
// Illegal selects (zero or several bits set) are always accepted and dropped,
// so a malformed request can never wedge the producer. Each drop is counted
// and raises a sticky error flag.
module demux_decoded_registered #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 8,
  parameter int DROP_CNT_WIDTH           = 8
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]   data_in,
  input  logic [NUM_WAY-1:0]                    sel_in,
  input  logic                                  valid_in,
  output logic                                  ready_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_out,
  output logic [NUM_WAY-1:0]                    way_valid_out,
  input  logic [NUM_WAY-1:0]                    way_ready_in,
  output logic                                  error_out,
  output logic [DROP_CNT_WIDTH-1:0]             drop_count_out
);

  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;

  logic               sel_legal;
  logic [NUM_WAY-1:0] slot_open;
  logic [NUM_WAY-1:0] load;
  logic [NUM_WAY-1:0] drain;
  logic               accept;
  logic [W-1:0]       slot_q [NUM_WAY];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_legal = (sel_in != '0) && ((sel_in & (sel_in - NUM_WAY'(1))) == '0);

  // A slot can take a word if it is empty or its consumer drains it this cycle.
  assign slot_open = ~way_valid_out | way_ready_in;
  assign ready_out = sel_legal ? |(sel_in & slot_open) : 1'b1;

  assign accept = valid_in & ready_out;
  assign load   = (accept && sel_legal) ? sel_in : '0;
  assign drain  = way_valid_out & way_ready_in;

  // Per-way valid: a load wins over a simultaneous drain, giving 1 word/cycle.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      way_valid_out <= '0;
    end else begin
      way_valid_out <= load | (way_valid_out & ~drain);
    end
  end

  // Per-way data slots; contents are held (not cleared) when a way drains.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WAY; i++) begin
        if (load[i]) begin
          slot_q[i] <= data_in;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_WAY; g++) begin : g_flat
    assign way_flatted_out[g*W +: W] = slot_q[g];
  end

  // Sticky error and saturating drop counter for accepted illegal selects.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      error_out      <= 1'b0;
      drop_count_out <= '0;
    end else if (accept && !sel_legal) begin
      error_out <= 1'b1;
      if (drop_count_out != '1) begin
        drop_count_out <= drop_count_out + DROP_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_decoded_registered.sv
// Bench for demux_decoded_registered: a table of per-cycle vectors plus
// hand-written sequences; per-way data is tracked by a queue scoreboard.
module tb_demux_decoded_registered;

  localparam int W  = 4;
  localparam int NW = 8;
  localparam int DW = 8;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [W-1:0]    data_in;
  logic [NW-1:0]   sel_in;
  logic            valid_in;
  logic            ready_out;
  logic [W*NW-1:0] way_flatted_out;
  logic [NW-1:0]   way_valid_out;
  logic [NW-1:0]   way_ready_in;
  logic            error_out;
  logic [DW-1:0]   drop_count_out;

  demux_decoded_registered #(
    .SINGLE_WAY_WIDTH_IN_BITS(W), .NUM_WAY(NW), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .sel_in(sel_in),
    .valid_in(valid_in), .ready_out(ready_out), .way_flatted_out(way_flatted_out),
    .way_valid_out(way_valid_out), .way_ready_in(way_ready_in),
    .error_out(error_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0]  data;
    logic [NW-1:0] sel;
    logic          valid;
    logic [NW-1:0] wready;
    logic          exp_ready;
    logic [NW-1:0] exp_wvalid;
    logic          exp_err;
    logic [DW-1:0] exp_drop;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int popped3  = 0;

  logic [W-1:0]  sbq [NW][$];
  logic [NW-1:0] exp_wv = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] slice(input int i);
    return way_flatted_out[i*W +: W];
  endfunction

  task automatic step(input vec_t v);
    logic [W-1:0] exp_d;
    @(negedge clk_in);
    data_in      = v.data;
    sel_in       = v.sel;
    valid_in     = v.valid;
    way_ready_in = v.wready;
    #1;
    chk("ready_out", 32'(ready_out), 32'(v.exp_ready));
    // Ways drained at the coming edge: the visible word must be the oldest queued one.
    for (int i = 0; i < NW; i++) begin
      if (exp_wv[i] && v.wready[i]) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("drain_empty_sb_w%0d", i), 32'(1), 32'(0));
        end else begin
          exp_d = sbq[i].pop_front();
          chk($sformatf("drain_data_w%0d", i), 32'(slice(i)), 32'(exp_d));
          if (i == 3) popped3++;
        end
      end
    end
    if (v.valid && v.exp_ready && $countones(v.sel) == 1) begin
      for (int i = 0; i < NW; i++) begin
        if (v.sel[i]) sbq[i].push_back(v.data);
      end
    end
    @(posedge clk_in);
    #1;
    exp_wv = v.exp_wvalid;
    chk("way_valid_out", 32'(way_valid_out), 32'(v.exp_wvalid));
    chk("error_out", 32'(error_out), 32'(v.exp_err));
    chk("drop_count_out", 32'(drop_count_out), 32'(v.exp_drop));
    for (int i = 0; i < NW; i++) begin
      if (v.exp_wvalid[i]) begin
        if (sbq[i].size() == 0) chk($sformatf("held_empty_sb_w%0d", i), 32'(1), 32'(0));
        else chk($sformatf("held_data_w%0d", i), 32'(slice(i)), 32'(sbq[i][0]));
      end
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_way_valid"}, 32'(way_valid_out), 32'(0));
    chk({tag, "_flatted"},   32'(way_flatted_out), 32'(0));
    chk({tag, "_error"},     32'(error_out), 32'(0));
    chk({tag, "_drop"},      32'(drop_count_out), 32'(0));
    chk({tag, "_ready"},     32'(ready_out), 32'(1));
  endtask

  vec_t tbl [13];
  vec_t v;
  logic [DW-1:0] dexp;

  initial begin
    // data, sel, valid, wready, exp_ready, exp_wvalid, exp_err, exp_drop
    tbl[0]  = '{4'hc, 8'h20, 1'b1, 8'h00, 1'b1, 8'h20, 1'b0, 8'd0};
    tbl[1]  = '{4'h5, 8'h20, 1'b1, 8'h00, 1'b0, 8'h20, 1'b0, 8'd0};
    tbl[2]  = '{4'h5, 8'h20, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0, 8'd0};
    tbl[3]  = '{4'h0, 8'h00, 1'b0, 8'h20, 1'b1, 8'h00, 1'b0, 8'd0};
    tbl[4]  = '{4'h9, 8'h20, 1'b1, 8'h00, 1'b1, 8'h20, 1'b0, 8'd0};
    tbl[5]  = '{4'h1, 8'h01, 1'b1, 8'h00, 1'b1, 8'h21, 1'b0, 8'd0};
    tbl[6]  = '{4'h2, 8'h80, 1'b1, 8'h00, 1'b1, 8'ha1, 1'b0, 8'd0};
    tbl[7]  = '{4'h3, 8'h00, 1'b1, 8'h00, 1'b1, 8'ha1, 1'b1, 8'd1};
    tbl[8]  = '{4'h3, 8'h11, 1'b1, 8'h00, 1'b1, 8'ha1, 1'b1, 8'd2};
    tbl[9]  = '{4'h7, 8'h03, 1'b0, 8'h00, 1'b1, 8'ha1, 1'b1, 8'd2};
    tbl[10] = '{4'h7, 8'h01, 1'b1, 8'h00, 1'b0, 8'ha1, 1'b1, 8'd2};
    tbl[11] = '{4'h7, 8'h02, 1'b0, 8'h00, 1'b1, 8'ha1, 1'b1, 8'd2};
    tbl[12] = '{4'h0, 8'h00, 1'b0, 8'hff, 1'b1, 8'h00, 1'b1, 8'd2};

    reset_in = 1'b1; data_in = '0; sel_in = '0; valid_in = 1'b0; way_ready_in = '0;
    #12;
    chk_reset_values("reset");
    @(negedge clk_in);
    reset_in = 1'b0;

    for (int k = 0; k < 13; k++) begin
      step(tbl[k]);
      if (k == 0) chk("first_accept_flat", 32'(way_flatted_out), 32'h00c0_0000);
      if (k == 6) begin
        chk("way0_slice", 32'(way_flatted_out[3:0]), 32'h1);
        chk("way7_slice", 32'(way_flatted_out[31:28]), 32'h2);
      end
    end

    // Saturating drop counter: 300 illegal inputs from a count of 2.
    for (int k = 0; k < 300; k++) begin
      dexp = (k + 3 > 255) ? 8'hff : DW'(k + 3);
      v = '{4'(k), (k % 2 == 0) ? 8'h00 : 8'hc0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, dexp};
      step(v);
    end
    chk("drop_saturated", 32'(drop_count_out), 32'hff);

    // Streaming 16 words into way 3 with the consumer always ready.
    for (int k = 0; k < 16; k++) begin
      v = '{4'(k), 8'h08, 1'b1, 8'h08, 1'b1, 8'h08, 1'b1, 8'hff};
      step(v);
    end
    v = '{4'h0, 8'h08, 1'b0, 8'h08, 1'b1, 8'h00, 1'b1, 8'hff};
    step(v);
    chk("stream_words_seen", 32'(popped3), 32'd16);

    // Fill ways 0, 3, 5 then assert reset between clock edges.
    v = '{4'ha, 8'h01, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1, 8'hff}; step(v);
    v = '{4'hb, 8'h08, 1'b1, 8'h00, 1'b1, 8'h09, 1'b1, 8'hff}; step(v);
    v = '{4'hd, 8'h20, 1'b1, 8'h00, 1'b1, 8'h29, 1'b1, 8'hff}; step(v);
    @(negedge clk_in);
    valid_in = 1'b0; sel_in = '0; way_ready_in = '0;
    #1;
    reset_in = 1'b1;
    #1;
    chk_reset_values("async_reset");
    #1;
    reset_in = 1'b0;
    for (int i = 0; i < NW; i++) sbq[i].delete();
    exp_wv = '0;

    // Post-reset: counter restarts from zero.
    v = '{4'h6, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 8'd1}; step(v);
    v = '{4'h6, 8'h04, 1'b1, 8'h00, 1'b1, 8'h04, 1'b1, 8'd1}; step(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_decoded_registered.md
Name: demux_decoded_registered

Overview:
- Registered one-hot demultiplexer: routes one input word to one of NUM_WAY output ways, chosen by a one-hot select.
- Each way has a single-entry output register with its own valid/ready handshake, so one slow consumer does not block the others.
- Counterpart of the one-hot-select way mux. Used where a producer fans out to per-way consumers such as cache ways or per-bank queues.

Parameters:
SINGLE_WAY_WIDTH_IN_BITS, 4, width of one data word / one way slice
NUM_WAY, 8, number of output ways (>=2)
DROP_CNT_WIDTH, 8, width of saturating counter of dropped (illegal-select) inputs

Ports:
clk_in  input  1  clock, all state updates on rising edge
reset_in  input  1  reset, asynchronous, active-high
data_in  input  SINGLE_WAY_WIDTH_IN_BITS  input word
sel_in  input  NUM_WAY  one-hot destination way; bit i selects way i
valid_in  input  1  data_in/sel_in valid
ready_out  output  1  block accepts input this cycle (combinational)
way_flatted_out  output  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  per-way registered data; way i at bits [i*W +: W]
way_valid_out  output  NUM_WAY  per-way data valid
way_ready_in  input  NUM_WAY  per-way consumer ready
error_out  output  1  sticky: an illegal select was accepted
drop_count_out  output  DROP_CNT_WIDTH  number of dropped inputs, saturating

Behaviour:
- Reset (async, active-high):
  - way_flatted_out = 0, way_valid_out = 0, error_out = 0, drop_count_out = 0.
  - ready_out follows its combinational equation: with all ways empty it is 1.
  - Reset asserted mid-operation discards all buffered words immediately; no partial state survives.
- Legal select = sel_in has exactly one bit set. Illegal = zero bits or more than one bit set.
- Drain of way i: way_valid_out[i] & way_ready_in[i] at the rising edge.
- ready_out, legal select: ready_out = slot i empty OR slot i draining this cycle. That is, ~way_valid_out[i] | way_ready_in[i], where i is the selected way.
- ready_out, illegal select: ready_out = 1.
- ready_out depends only on sel_in, way_valid_out and way_ready_in. It never depends on valid_in.
- Accept = valid_in & ready_out at the rising edge.
- Legal accept into way i:
  - way i data slice <= data_in; way_valid_out[i] <= 1.
  - Latency is 1 cycle: data is visible on way_flatted_out the cycle after acceptance.
- Simultaneous drain and load of the same way: the new word replaces the old one and way_valid_out[i] stays 1. This gives full throughput of 1 word/cycle per way.
- Drain with no load: way_valid_out[i] <= 0. The data slice holds its last value; it is don't-care while invalid and is not cleared.
- Ways not selected are unaffected by an accept. They drain independently, and any number of ways may drain in the same cycle.
- Illegal accept:
  - No way is written.
  - error_out <= 1; it stays 1 until reset.
  - drop_count_out increments by 1 and saturates at all-ones, with no wrap.
- valid_in = 0: no write and no counter change, regardless of sel_in.
- No combinational path from data_in to any output.
- way_valid_out and way_flatted_out are driven only by flops.

Test Plan:
- After reset: way_valid_out=8'h00, ready_out=1, error_out=0, drop_count_out=0. Data 4'hc with sel_in=8'b0010_0000, valid_in=1, way_ready_in=0 for one cycle -> next cycle way_valid_out=8'b0010_0000, way_flatted_out[23:20]=4'hc, all other slices 0.
- Backpressure, from the previous state: present 4'h5 to way 5 with way_ready_in=0 -> ready_out=0, way 5 still holds 4'hc. Then raise way_ready_in[5]=1 with input still valid -> 4'h5 accepted and way_valid_out[5] stays 1. Next cycle with valid_in=0 -> way_valid_out[5]=0.
- Independence: way 5 full and stalled; send 4'h1 to way 0 and 4'h2 to way 7 on consecutive cycles -> both accepted with ready_out=1, way_valid_out=8'b1010_0001, slices [3:0]=4'h1, [31:28]=4'h2.
- Illegal select: sel_in=8'b0000_0000 then 8'b0001_0001, valid_in=1 -> ready_out=1 both cycles, no way_valid_out change, error_out=1, drop_count_out=2. Feed 300 illegal inputs -> drop_count_out=8'hff.
- Streaming: 16 consecutive words 4'h0..4'hf to way 3 with way_ready_in[3]=1 -> ready_out=1 every cycle. Consumer sees all 16 words in order, one per cycle, starting 1 cycle after the first accept.
- Reset mid-operation: ways 0, 3 and 5 valid, error_out=1; pulse reset_in asynchronously between clock edges -> all outputs return to reset values immediately, without waiting for a clock edge.
